// File: rtl/slice_rr_arb.sv
// Round-robin arbiter feeding one registered pipeline slice.
// A requester is granted for a whole packet; the grant is released only
// after its last beat has been accepted. Each new grant costs one idle
// arbitration cycle.
module slice_rr_arb #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int SRC_W      = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_last,
  output logic [SRC_W-1:0]            out_src,
  input  logic                        out_ready
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t                  r_state;
  logic [SRC_W-1:0]        r_grant;
  logic [SRC_W-1:0]        r_rr_ptr;
  logic                    r_out_valid_p1;
  logic [DATA_WIDTH-1:0]   r_out_data_p1;
  logic                    r_out_last_p1;
  logic [SRC_W-1:0]        r_out_src_p1;

  logic                    w_stage_free;
  logic [N_REQ-1:0]        w_ready;
  logic [DATA_WIDTH-1:0]   w_beat;
  logic                    w_beat_last;
  logic                    w_gnt_valid;
  logic                    w_accept;
  logic [2*N_REQ-1:0]      w_rot_dbl;
  logic [N_REQ-1:0]        w_rot;
  logic [SRC_W-1:0]        w_next_grant;

  // The slice can take a new beat when empty or when it drains this cycle.
  assign w_stage_free = ~r_out_valid_p1 | out_ready;

  // Select the granted requester's beat and drive its ready; all others stay 0.
  always_comb begin
    w_ready     = '0;
    w_beat      = '0;
    w_beat_last = 1'b0;
    w_gnt_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant == SRC_W'(i)) begin
        w_beat      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_beat_last = req_last[i];
        w_gnt_valid = req_valid[i];
        if (rstn && (r_state == ST_LOCK)) begin
          w_ready[i] = w_stage_free;
        end
      end
    end
  end

  assign req_ready = w_ready;
  assign w_accept  = (r_state == ST_LOCK) & w_gnt_valid & w_stage_free;

  // Rotate the valid vector so bit 0 is rr_ptr, then take the lowest set bit.
  assign w_rot_dbl = {req_valid, req_valid} >> r_rr_ptr;
  assign w_rot     = w_rot_dbl[N_REQ-1:0];

  // Map the lowest set rotated bit back to an absolute requester index.
  always_comb begin
    int off;
    int sum;
    off = 0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        off = j;
      end
    end
    sum = int'(r_rr_ptr) + off;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end
    w_next_grant = SRC_W'(sum);
  end

  // Arbitration FSM and output register of the slice.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state        <= ST_IDLE;
      r_grant        <= '0;
      r_rr_ptr       <= '0;
      r_out_valid_p1 <= 1'b0;
      r_out_data_p1  <= '0;
      r_out_last_p1  <= 1'b0;
      r_out_src_p1   <= '0;
    end else begin
      // stage p1: load on acceptance, otherwise drop valid once drained
      if (w_accept) begin
        r_out_valid_p1 <= 1'b1;
        r_out_data_p1  <= w_beat;
        r_out_last_p1  <= w_beat_last;
        r_out_src_p1   <= r_grant;
      end else if (r_out_valid_p1 && out_ready) begin
        r_out_valid_p1 <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (|req_valid) begin
            r_grant <= w_next_grant;
            r_state <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (w_accept && w_beat_last) begin
            r_rr_ptr <= (r_grant == SRC_W'(N_REQ - 1)) ? '0 : r_grant + SRC_W'(1);
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid_p1;
  assign out_data  = r_out_data_p1;
  assign out_last  = r_out_last_p1;
  assign out_src   = r_out_src_p1;

endmodule

// File: tb/tb_slice_rr_arb.sv
// Directed bench for slice_rr_arb: a vector table for reset and fair
// rotation, plus hand-written sequences for backpressure, lock hold,
// pointer wrap and mid-packet reset.
module tb_slice_rr_arb;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [SW-1:0]   out_src;
  logic            out_ready;

  int checks = 0;
  int errors = 0;

  slice_rr_arb #(.N_REQ(N), .DATA_WIDTH(DW), .SRC_W(SW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_src(out_src), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rstn;
    logic [3:0]    vld;
    logic [3:0]    lst;
    logic          ordy;
    logic [7:0]    d;
    logic [3:0]    e_rdy;
    logic          e_ov;
    logic [63:0]   e_od;
    logic          e_ol;
    logic [1:0]    e_os;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] l, logic o,
                              logic [7:0] d, logic [3:0] erdy, logic eov,
                              logic [63:0] eod, logic eol, logic [1:0] eos);
    vec_t t;
    t.rstn = r; t.vld = v; t.lst = l; t.ordy = o; t.d = d;
    t.e_rdy = erdy; t.e_ov = eov; t.e_od = eod; t.e_ol = eol; t.e_os = eos;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [63:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic chk_out(input string name, input logic ov, input logic [63:0] od,
                         input logic ol, input logic [1:0] os);
    chk({name, "_ov"}, 64'(out_valid), 64'(ov));
    chk({name, "_od"}, out_data, od);
    chk({name, "_ol"}, 64'(out_last), 64'(ol));
    chk({name, "_os"}, 64'(out_src), 64'(os));
  endtask

  initial begin
    logic [15:0] bp_pat;
    int          b;
    int          rx;
    logic        prev_stall;
    logic [63:0] prev_data;
    logic        acc;

    // reset / rotation table: inputs applied in cycle k, outputs checked before its edge
    tbl[0]  = mk(1'b0, 4'hF, 4'h0, 1'b1, 8'h00, 4'h0, 1'b0, 64'h000, 1'b0, 2'd0);
    tbl[1]  = mk(1'b0, 4'hF, 4'h0, 1'b1, 8'h00, 4'h0, 1'b0, 64'h000, 1'b0, 2'd0);
    tbl[2]  = mk(1'b0, 4'hF, 4'h0, 1'b1, 8'h00, 4'h0, 1'b0, 64'h000, 1'b0, 2'd0);
    tbl[3]  = mk(1'b1, 4'hF, 4'h0, 1'b1, 8'h01, 4'h0, 1'b0, 64'h000, 1'b0, 2'd0);
    tbl[4]  = mk(1'b1, 4'hF, 4'h0, 1'b1, 8'h02, 4'h1, 1'b0, 64'h000, 1'b0, 2'd0);
    tbl[5]  = mk(1'b1, 4'hF, 4'hF, 1'b1, 8'h03, 4'h1, 1'b1, 64'h002, 1'b0, 2'd0);
    tbl[6]  = mk(1'b1, 4'hF, 4'h0, 1'b1, 8'h04, 4'h0, 1'b1, 64'h003, 1'b1, 2'd0);
    tbl[7]  = mk(1'b1, 4'hF, 4'h0, 1'b1, 8'h05, 4'h2, 1'b0, 64'h003, 1'b1, 2'd0);
    tbl[8]  = mk(1'b1, 4'hF, 4'hF, 1'b1, 8'h06, 4'h2, 1'b1, 64'h105, 1'b0, 2'd1);
    tbl[9]  = mk(1'b1, 4'hF, 4'h0, 1'b1, 8'h07, 4'h0, 1'b1, 64'h106, 1'b1, 2'd1);
    tbl[10] = mk(1'b1, 4'hF, 4'h0, 1'b1, 8'h08, 4'h4, 1'b0, 64'h106, 1'b1, 2'd1);
    tbl[11] = mk(1'b1, 4'hF, 4'hF, 1'b1, 8'h09, 4'h4, 1'b1, 64'h208, 1'b0, 2'd2);
    tbl[12] = mk(1'b1, 4'hF, 4'h0, 1'b1, 8'h0A, 4'h0, 1'b1, 64'h209, 1'b1, 2'd2);
    tbl[13] = mk(1'b1, 4'hF, 4'h0, 1'b1, 8'h0B, 4'h8, 1'b0, 64'h209, 1'b1, 2'd2);
    tbl[14] = mk(1'b1, 4'hF, 4'hF, 1'b1, 8'h0C, 4'h8, 1'b1, 64'h30B, 1'b0, 2'd3);
    tbl[15] = mk(1'b1, 4'hF, 4'h0, 1'b1, 8'h0D, 4'h0, 1'b1, 64'h30C, 1'b1, 2'd3);
    tbl[16] = mk(1'b1, 4'hF, 4'h0, 1'b1, 8'h0E, 4'h1, 1'b0, 64'h30C, 1'b1, 2'd3);
    tbl[17] = mk(1'b1, 4'hF, 4'hF, 1'b1, 8'h0F, 4'h1, 1'b1, 64'h00E, 1'b0, 2'd0);
    tbl[18] = mk(1'b1, 4'h0, 4'h0, 1'b1, 8'h10, 4'h0, 1'b1, 64'h00F, 1'b1, 2'd0);
    tbl[19] = mk(1'b1, 4'h0, 4'h0, 1'b1, 8'h11, 4'h0, 1'b0, 64'h00F, 1'b1, 2'd0);

    rstn = 1'b0; req_valid = '1; req_last = '0; req_data = '0; out_ready = 1'b1;
    cyc();

    for (int k = 0; k < 20; k++) begin
      rstn      = tbl[k].rstn;
      req_valid = tbl[k].vld;
      req_last  = tbl[k].lst;
      out_ready = tbl[k].ordy;
      for (int i = 0; i < N; i++) set_data(i, 64'(i * 256) | 64'(tbl[k].d));
      #1;
      chk($sformatf("tbl%0d_rdy", k), 64'(req_ready), 64'(tbl[k].e_rdy));
      chk_out($sformatf("tbl%0d", k), tbl[k].e_ov, tbl[k].e_od, tbl[k].e_ol, tbl[k].e_os);
      cyc();
    end

    // backpressure: requester 1 sends 0x11..0x14 with out_ready 1,0,0,1,1,0,1,1,...
    req_data = '0; req_valid = '0; req_last = '0;
    bp_pat = 16'b1111_1111_1101_1001;
    b = 0; rx = 0; prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 40 && rx < 4; c++) begin
      req_valid[1] = (b < 4);
      req_last[1]  = (b == 3);
      set_data(1, 64'(8'h11 + b));
      out_ready = (c < 16) ? bp_pat[c] : 1'b1;
      #1;
      if (prev_stall) chk($sformatf("bp_hold%0d", c), out_data, prev_data);
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        chk($sformatf("bp_data%0d", rx), out_data, 64'(8'h11 + rx));
        chk($sformatf("bp_last%0d", rx), 64'(out_last), 64'(rx == 3));
        chk($sformatf("bp_src%0d", rx), 64'(out_src), 64'd1);
        rx++;
      end
      acc = req_ready[1] & req_valid[1];
      cyc();
      if (acc) b++;
    end
    chk("bp_count", 64'(rx), 64'd4);
    req_valid = '0; out_ready = 1'b1;
    #1;
    chk("bp_drained", 64'(out_valid), 64'd0);
    cyc();

    // lock hold: requester 2 (rr_ptr=2) pauses mid-packet while 0 and 3 wait
    req_data = '0; req_last = '0;
    req_valid = 4'b1101; set_data(2, 64'h21); set_data(3, 64'h31); set_data(0, 64'h01);
    #1; chk("lk_idle_rdy", 64'(req_ready), 64'h0); cyc();
    #1; chk("lk_b1_rdy", 64'(req_ready), 64'h4); cyc();
    req_valid = 4'b1001;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("lk_pause%0d_rdy", c), 64'(req_ready), 64'h4);
      if (c == 0) chk_out("lk_b1_out", 1'b1, 64'h21, 1'b0, 2'd2);
      if (c == 1) chk("lk_drain_ov", 64'(out_valid), 64'd0);
      cyc();
    end
    req_valid = 4'b1101; set_data(2, 64'h22);
    #1; chk("lk_b2_rdy", 64'(req_ready), 64'h4); cyc();
    set_data(2, 64'h23); req_last[2] = 1'b1;
    #1; chk("lk_b3_rdy", 64'(req_ready), 64'h4); chk_out("lk_b2_out", 1'b1, 64'h22, 1'b0, 2'd2); cyc();
    // wrap: rr_ptr=3 with 0 and 3 valid
    req_valid = 4'b1001; req_last = 4'b1001;
    #1; chk("wr_idle_rdy", 64'(req_ready), 64'h0); chk_out("lk_b3_out", 1'b1, 64'h23, 1'b1, 2'd2); cyc();
    #1; chk("wr_g3_rdy", 64'(req_ready), 64'h8); cyc();
    #1; chk("wr_idle2_rdy", 64'(req_ready), 64'h0); chk_out("wr_g3_out", 1'b1, 64'h31, 1'b1, 2'd3); cyc();
    #1; chk("wr_g0_rdy", 64'(req_ready), 64'h1); cyc();
    req_valid = '0; req_last = '0;
    #1; chk_out("wr_g0_out", 1'b1, 64'h01, 1'b1, 2'd0); cyc();
    cyc();

    // mid-packet reset: requester 1 (rr_ptr=1) loses its packet during beat 2
    req_valid = 4'b0011; set_data(1, 64'h41); set_data(0, 64'h51);
    #1; chk("mr_idle_rdy", 64'(req_ready), 64'h0); cyc();
    #1; chk("mr_b1_rdy", 64'(req_ready), 64'h2); cyc();
    set_data(1, 64'h42); rstn = 1'b0;
    #1; chk("mr_rst_rdy", 64'(req_ready), 64'h0); chk_out("mr_b1_out", 1'b1, 64'h41, 1'b0, 2'd1); cyc();
    rstn = 1'b1;
    #1; chk("mr_after_rdy", 64'(req_ready), 64'h0); chk_out("mr_after", 1'b0, 64'h0, 1'b0, 2'd0); cyc();
    #1; chk("mr_regrant_rdy", 64'(req_ready), 64'h1); cyc();
    req_valid = '0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
